// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter and sequencer for a single-port byte-addressed memory.
// Each grant is registered (ACCEPT), driven for one access cycle (ACCESS), then answered (RESPOND).
module mem_port_arbiter #(
    parameter int unsigned BYTE_SIZE  = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MEM_BYTES  = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0,
    input  logic                    req1,
    input  logic                    we0,
    input  logic                    we1,
    input  logic [ADDR_WIDTH-1:0]   addr0,
    input  logic [ADDR_WIDTH-1:0]   addr1,
    input  logic [8*BYTE_SIZE-1:0]  wd0,
    input  logic [8*BYTE_SIZE-1:0]  wd1,
    output logic                    gnt0,
    output logic                    gnt1,
    output logic                    rvalid0,
    output logic                    rvalid1,
    output logic [8*BYTE_SIZE-1:0]  rd0,
    output logic [8*BYTE_SIZE-1:0]  rd1,
    output logic                    err0,
    output logic                    err1,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [8*BYTE_SIZE-1:0]  mem_wd,
    input  logic [8*BYTE_SIZE-1:0]  mem_rd
);

    localparam int unsigned DataWidth = 8 * BYTE_SIZE;
    localparam logic [ADDR_WIDTH-1:0] MaxAddr = ADDR_WIDTH'(MEM_BYTES - BYTE_SIZE);

    // Round-robin state: owner of the most recent accepted transaction
    logic last_gnt_q;

    // Command register (ACCESS stage)
    logic                  cmd_valid_q;
    logic                  cmd_owner_q;
    logic                  cmd_we_q;
    logic                  cmd_oor_q;
    logic [ADDR_WIDTH-1:0] cmd_addr_q;
    logic [DataWidth-1:0]  cmd_wd_q;

    // Response register (RESPOND stage)
    logic                  resp_valid_q;
    logic                  resp_owner_q;
    logic                  resp_err_q;
    logic [DataWidth-1:0]  resp_data_q;

    // Selected request
    logic                  accept;
    logic                  acc_owner;
    logic                  acc_we;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DataWidth-1:0]  acc_wd;
    logic                  acc_oor;
    logic [DataWidth-1:0]  resp_data_d;

    // On a tie the port that did not win last time gets the grant
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            if (last_gnt_q) begin
                gnt0 = 1'b1;
            end else begin
                gnt1 = 1'b1;
            end
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

    always_comb begin
        accept    = (req0 & gnt0) | (req1 & gnt1);
        acc_owner = gnt1;
        acc_we    = gnt1 ? we1   : we0;
        acc_addr  = gnt1 ? addr1 : addr0;
        acc_wd    = gnt1 ? wd1   : wd0;
        acc_oor   = (acc_addr > MaxAddr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_gnt_q  <= 1'b1;
            cmd_valid_q <= 1'b0;
            cmd_owner_q <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_oor_q   <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wd_q    <= '0;
        end else begin
            cmd_valid_q <= accept;
            if (accept) begin
                last_gnt_q  <= acc_owner;
                cmd_owner_q <= acc_owner;
                cmd_we_q    <= acc_we;
                cmd_oor_q   <= acc_oor;
                cmd_addr_q  <= acc_addr;
                cmd_wd_q    <= acc_wd;
            end
        end
    end

    // Out-of-range commands park the address at 0 and never write
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        if (cmd_valid_q) begin
            mem_we   = cmd_we_q & ~cmd_oor_q;
            mem_addr = cmd_oor_q ? '0 : cmd_addr_q;
            mem_wd   = cmd_wd_q;
        end
    end

    always_comb begin
        resp_data_d = '0;
        if (cmd_valid_q && !cmd_we_q && !cmd_oor_q) begin
            resp_data_d = mem_rd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_owner_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            resp_valid_q <= cmd_valid_q;
            resp_owner_q <= cmd_owner_q;
            resp_err_q   <= cmd_valid_q & cmd_oor_q;
            resp_data_q  <= resp_data_d;
        end
    end

    always_comb begin
        rvalid0 = resp_valid_q & ~resp_owner_q;
        rvalid1 = resp_valid_q &  resp_owner_q;
        rd0     = rvalid0 ? resp_data_q : '0;
        rd1     = rvalid1 ? resp_data_q : '0;
        err0    = rvalid0 & resp_err_q;
        err1    = rvalid1 & resp_err_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte memory model, reference memory and an in-order response
// scoreboard, driven by directed steps followed by random two-port traffic.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wd0 = '0, wd1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_we;
    logic [31:0] rd0, rd1, mem_addr, mem_wd, mem_rd;

    mem_port_arbiter #(
        .BYTE_SIZE (4),
        .ADDR_WIDTH(32),
        .MEM_BYTES (4096)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0),
        .req1    (req1),
        .we0     (we0),
        .we1     (we1),
        .addr0   (addr0),
        .addr1   (addr1),
        .wd0     (wd0),
        .wd1     (wd1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .rvalid0 (rvalid0),
        .rvalid1 (rvalid1),
        .rd0     (rd0),
        .rd1     (rd1),
        .err0    (err0),
        .err1    (err1),
        .mem_we  (mem_we),
        .mem_addr(mem_addr),
        .mem_wd  (mem_wd),
        .mem_rd  (mem_rd)
    );

    always #5 clk = ~clk;

    logic [7:0] mem     [0:4095];
    logic [7:0] ref_mem [0:4095];

    always_comb begin
        mem_rd = '0;
        if (mem_addr <= 32'd4092) begin
            for (int b = 0; b < 4; b++) mem_rd[8*b +: 8] = mem[int'(mem_addr) + b];
        end
    end

    always @(posedge clk) begin
        if (mem_we && mem_addr <= 32'd4092) begin
            for (int b = 0; b < 4; b++) mem[int'(mem_addr) + b] <= mem_wd[8*b +: 8];
        end
    end

    typedef struct {
        bit          port;
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   we_cycles = 0;
    bit   model_en = 1'b1;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int a);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = ref_mem[a + b];
        return w;
    endfunction

    function automatic logic [31:0] mem_word(input int a);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = mem[a + b];
        return w;
    endfunction

    // Acceptance order is commit order, so the reference memory is updated at acceptance
    task automatic model_accept(input bit port, input logic w, input logic [31:0] a,
                                input logic [31:0] d);
        exp_t e;
        e.port = port;
        e.cyc  = cyc + 2;
        e.err  = (a > 32'd4092);
        e.rd   = '0;
        if (!e.err) begin
            if (w) begin
                for (int b = 0; b < 4; b++) ref_mem[int'(a) + b] = d[8*b +: 8];
            end else begin
                e.rd = ref_word(int'(a));
            end
        end
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
            check("gnt_without_req", 32'((gnt0 & ~req0) | (gnt1 & ~req1)), 32'd0);
            if (mem_we) we_cycles++;
            if (model_en && req0 && gnt0) model_accept(1'b0, we0, addr0, wd0);
            if (model_en && req1 && gnt1) model_accept(1'b1, we1, addr1, wd1);
            if (rvalid0 || rvalid1) begin
                check("rvalid_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rvalid_port", 32'({rvalid1, rvalid0}), e.port ? 32'd2 : 32'd1);
                    check("rd_owner", e.port ? rd1 : rd0, e.rd);
                    check("err_owner", 32'(e.port ? err1 : err0), 32'(e.err));
                    check("rd_other", e.port ? rd0 : rd1, 32'd0);
                    check("err_other", 32'(e.port ? err0 : err1), 32'd0);
                    check("latency", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned k;
        k = $urandom_range(0, 19);
        if (k == 0) return 32'd4093;
        if (k == 1) return 32'd4092;
        return 32'($urandom_range(0, 40));
    endfunction

    initial begin
        logic g0, g1;
        logic [31:0] old16;
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        for (int b = 0; b < 4; b++) begin
            mem[b]     = 8'(8'h11 * (b + 1));
            ref_mem[b] = mem[b];
        end

        // Reset state
        #2 reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_gnt", 32'({gnt1, gnt0}), 32'd0);
        check("reset_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
        check("reset_rd0", rd0, 32'd0);
        check("reset_rd1", rd1, 32'd0);
        check("reset_err", 32'({err1, err0}), 32'd0);
        check("reset_mem_we", 32'(mem_we), 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_mem_wd", mem_wd, 32'd0);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Single read at byte 0
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd0;
        #1 check("read_gnt0", 32'({gnt1, gnt0}), 32'd1);
        @(posedge clk);
        #1 req0 = 1'b0;
        @(posedge clk);
        #1;
        check("read_rvalid0", 32'(rvalid0), 32'd1);
        check("read_rd0", rd0, 32'h44332211);
        check("read_err0", 32'(err0), 32'd0);
        repeat (3) @(posedge clk);
        #1;

        // Write on port 1 then read on port 0, same address
        we_cycles = 0;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'd8; wd1 = 32'hDEADBEEF;
        @(posedge clk);
        #1 req1 = 1'b0; we1 = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd8;
        @(posedge clk);
        #1 req0 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("hazard_we_cycles", 32'(we_cycles), 32'd1);
        check("hazard_mem8", mem_word(8), 32'hDEADBEEF);

        // Contention from reset: grants alternate starting with port 0
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h20;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h24;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("contend_gnt", 32'({gnt1, gnt0}), (i % 2 == 0) ? 32'd1 : 32'd2);
            @(posedge clk);
            #1;
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Out of range read/write plus the last legal address
        we_cycles = 0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd4093;
        @(posedge clk);
        #1 req0 = 1'b0;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'd4093; wd1 = 32'hCAFEF00D;
        @(posedge clk);
        #1 req1 = 1'b0; we1 = 1'b0;
        req0 = 1'b1; addr0 = 32'd4092;
        @(posedge clk);
        #1 req0 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("oor_we_cycles", 32'(we_cycles), 32'd0);
        check("oor_mem_top", mem_word(4092), ref_word(4092));
        check("oor_mem_zero", mem_word(0), ref_word(0));

        // Reset during the ACCESS cycle of a write
        old16 = mem_word(16);
        model_en = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd16; wd0 = 32'h12345678;
        @(posedge clk);
        #1 req0 = 1'b0; we0 = 1'b0;
        check("flight_mem_we", 32'(mem_we), 32'd1);
        check("flight_mem_addr", mem_addr, 32'd16);
        #2 reset = 1'b1;
        #1;
        check("flight_reset_we", 32'(mem_we), 32'd0);
        check("flight_reset_addr", mem_addr, 32'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        model_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("flight_no_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
        end
        check("flight_mem16", mem_word(16), old16);
        @(posedge clk);
        #1;

        // Random traffic; each port holds its request until granted
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            g0 = req0 & gnt0;
            g1 = req1 & gnt1;
            @(posedge clk);
            #1;
            if (g0 || !req0) begin
                req0 = ($urandom_range(0, 3) != 0);
                we0 = 1'($urandom);
                addr0 = rand_addr();
                wd0 = $urandom;
            end
            if (g1 || !req1) begin
                req1 = ($urandom_range(0, 3) != 0);
                we1 = 1'($urandom);
                addr1 = rand_addr();
                wd1 = $urandom;
            end
        end
        @(negedge clk);
        g0 = req0 & gnt0;
        g1 = req1 & gnt1;
        // Let any still-pending request through before stopping
        for (int i = 0; i < 4 && (req0 || req1); i++) begin
            @(posedge clk);
            #1;
            if (g0) req0 = 1'b0;
            if (g1) req1 = 1'b0;
            @(negedge clk);
            g0 = req0 & gnt0;
            g1 = req1 & gnt1;
        end
        repeat (5) @(posedge clk);
        #1;
        check("drain_empty", 32'(sb.size()), 32'd0);
        check("final_mem8", mem_word(8), ref_word(8));
        check("final_mem32", mem_word(32), ref_word(32));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
